sdvm_online: RTL

Parametrised signed-digit vector multiplier stage for the online multiplier datapath. It builds an N-digit signed-digit operand one digit per accepted cycle, most significant digit first, in plus/minus rail form. It multiplies that operand by a selector digit in {+1, 0, −1} delayed by a configurable number of cycles. Successor to the fixed 4-bit, one-cycle-delay selector: adds operand accumulation, depth/width parameters, valid/ready flow control, filled-position masking and a true-negation mode.

---
 rtl/sdvm_online.sv | 119 +++++++++++
 1 files changed

// File: rtl/sdvm_online.sv
// Signed-digit vector multiplier stage: builds an N-digit plus/minus-rail operand
// MSD first and multiplies it by a selector digit delayed DELAY cycles.
module sdvm_online #(
    parameter int NUM_DIGITS = 8,
    parameter int DELAY      = 1,
    parameter int NEG_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            vec_dig_in,
    input  logic [1:0]            sel_dig_in,
    output logic [NUM_DIGITS-1:0] vec_out_plus,
    output logic [NUM_DIGITS-1:0] vec_out_minus,
    output logic                  out_valid,
    output logic                  done,
    output logic                  busy
);

    localparam int CW = $clog2(NUM_DIGITS + 1);
    localparam logic [NUM_DIGITS-1:0] TOP_SLOT = {1'b1, {(NUM_DIGITS-1){1'b0}}};
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(NUM_DIGITS - 1);

    typedef struct packed {
        logic [1:0] sel;
        logic       v;
        logic       last;
    } stage_t;

    logic [NUM_DIGITS-1:0] opnd_p;
    logic [NUM_DIGITS-1:0] opnd_m;
    logic [NUM_DIGITS-1:0] mask;
    logic [NUM_DIGITS-1:0] slot;
    logic [CW-1:0]         cnt;
    logic                  accept;
    stage_t                stages [DELAY];
    stage_t                tail;

    // start takes priority over a coincident digit, so it also gates in_ready.
    assign in_ready = busy && (cnt < CNT_FULL) && !start;
    assign accept   = in_valid && in_ready;
    assign slot     = TOP_SLOT >> cnt;

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opnd_p <= '0;
            opnd_m <= '0;
            mask   <= '0;
            cnt    <= '0;
        end else if (start) begin
            opnd_p <= '0;
            opnd_m <= '0;
            mask   <= '0;
            cnt    <= '0;
        end else if (accept) begin
            opnd_p <= opnd_p | (slot & {NUM_DIGITS{vec_dig_in == 2'b10}});
            opnd_m <= opnd_m | (slot & {NUM_DIGITS{vec_dig_in == 2'b01}});
            mask   <= mask | slot;
            cnt    <= cnt + CW'(1);
        end
    end

    // NOTE: the delay line is reset like ordinary flops because its valid bits
    // must be clean out of reset; it is only DELAY entries deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) stages[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < DELAY; i++) stages[i] <= '0;
        end else begin
            stages[0] <= accept ? stage_t'{sel: sel_dig_in, v: 1'b1, last: (cnt == CNT_LAST)}
                                : stage_t'('0);
            for (int i = 1; i < DELAY; i++) stages[i] <= stages[i-1];
        end
    end

    assign tail      = stages[DELAY-1];
    assign out_valid = tail.v;
    assign done      = tail.v && tail.last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     busy <= 1'b0;
        else if (start) busy <= 1'b1;
        else if (done)  busy <= 1'b0;
    end

    // NOTE: both rails get a default first so no path through the case infers a latch.
    always_comb begin
        vec_out_plus  = '0;
        vec_out_minus = '0;
        if (tail.v) begin
            case (tail.sel)
                2'b10: begin
                    vec_out_plus  = opnd_p;
                    vec_out_minus = opnd_m;
                end
                2'b01: begin
                    if (NEG_MODE != 0) begin
                        vec_out_plus  = opnd_m;
                        vec_out_minus = opnd_p;
                    end else begin
                        vec_out_plus  = ~opnd_p & mask;
                        vec_out_minus = ~opnd_m & mask;
                    end
                end
                default: begin
                    vec_out_plus  = '0;
                    vec_out_minus = '0;
                end
            endcase
        end
    end

endmodule
